// File: rtl/field_dispatch_pkg.sv
// Shared types and constants for the protobuf field dispatcher: wire types,
// FSM encodings and the lane classification rule.
package field_dispatch_pkg;

    localparam int IDX_W                = 10;
    localparam int DEFAULT_MAX_INFLIGHT = 512;
    localparam int DEFAULT_CNT_W        = 11;

    localparam logic [2:0] WT_VARINT = 3'd0;
    localparam logic [2:0] WT_FIX64  = 3'd1;
    localparam logic [2:0] WT_LEN    = 3'd2;
    localparam logic [2:0] WT_SGRP   = 3'd3;
    localparam logic [2:0] WT_EGRP   = 3'd4;
    localparam logic [2:0] WT_FIX32  = 3'd5;

    typedef enum logic [4:0] {
        INIT    = 5'b00001,
        WAIT    = 5'b00010,
        V_ISSUE = 5'b00100,
        R_ISSUE = 5'b01000,
        DROP    = 5'b10000
    } state_e;

    typedef enum logic [1:0] {
        LANE_VARINT = 2'd0,
        LANE_RAW    = 2'd1,
        LANE_UNSUP  = 2'd2
    } lane_e;

    // Group markers (SGRP/EGRP) and the reserved codes 6/7 fall into LANE_UNSUP.
    function automatic lane_e classifyWireType(input logic [2:0] wt);
        case (wt)
            WT_VARINT:                 return LANE_VARINT;
            WT_FIX64, WT_LEN, WT_FIX32: return LANE_RAW;
            default:                   return LANE_UNSUP;
        endcase
    endfunction

endpackage

// File: rtl/field_dispatch_if.sv
// Bundle of the descriptor FIFO, lane FIFO and merge-stage signals around the
// dispatcher. The master modport is the dispatcher itself.
interface field_dispatch_if;

    logic                                  in_fifo_empty;
    logic [2:0]                            in_fifo_q;
    logic                                  in_fifo_pop;
    logic                                  varint_fifo_full;
    logic                                  varint_fifo_clr;
    logic                                  varint_fifo_push;
    logic [field_dispatch_pkg::IDX_W-1:0]  varint_fifo_index;
    logic                                  raw_fifo_full;
    logic                                  raw_fifo_clr;
    logic                                  raw_fifo_push;
    logic [field_dispatch_pkg::IDX_W-1:0]  raw_fifo_index;
    logic                                  retire;
    logic                                  busy;
    logic                                  err;

    modport master (
        input  in_fifo_empty, in_fifo_q, varint_fifo_full, raw_fifo_full, retire,
        output in_fifo_pop, varint_fifo_clr, varint_fifo_push, varint_fifo_index,
               raw_fifo_clr, raw_fifo_push, raw_fifo_index, busy, err
    );

    modport slave (
        output in_fifo_empty, in_fifo_q, varint_fifo_full, raw_fifo_full, retire,
        input  in_fifo_pop, varint_fifo_clr, varint_fifo_push, varint_fifo_index,
               raw_fifo_clr, raw_fifo_push, raw_fifo_index, busy, err
    );

endinterface

// File: rtl/field_dispatch_credit_counter.sv
// Up/down in-flight record counter: issue adds a credit use, retire returns one.
// A retire with nothing outstanding is ignored and reported as underflow.
module credit_counter #(
    parameter int MAX_COUNT = 512,
    parameter int CNT_W     = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic issue_i,
    input  logic retire_i,
    output logic at_max_o,
    output logic nonzero_o,
    output logic underflow_o
);

    localparam logic [CNT_W-1:0] MaxCount = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             retireOk;

    assign retireOk = retire_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (issue_i && !retireOk && (count_q != MaxCount)) begin
            count_d = count_q + CNT_W'(1);
        end else if (!issue_i && retireOk) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_max_o    = (count_q == MaxCount);
    assign nonzero_o   = (count_q != '0);
    assign underflow_o = retire_i && (count_q == '0) && !clear_i;

endmodule

// File: rtl/field_dispatch.sv
// Field dispatcher: pops wire-typed descriptors in strict order and steers them
// to the varint or raw lane with a wrapping index, bounded by in-flight credits.
module field_dispatch
    import field_dispatch_pkg::*;
#(
    parameter int MAX_INFLIGHT = DEFAULT_MAX_INFLIGHT,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    field_dispatch_if.master bus
);

    state_e             state_q;
    state_e             state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic               err_q;
    logic               err_d;

    logic               vClr;
    logic               rClr;
    logic               vPush;
    logic               rPush;
    logic               pop;
    logic               atMax;
    logic               nonzero;
    logic               underflow;
    lane_e              headLane;

    assign headLane = classifyWireType(bus.in_fifo_q);

    credit_counter #(
        .MAX_COUNT (MAX_INFLIGHT),
        .CNT_W     (CNT_W)
    ) u_credit (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (state_q == INIT),
        .issue_i     (vPush | rPush),
        .retire_i    (bus.retire),
        .at_max_o    (atMax),
        .nonzero_o   (nonzero),
        .underflow_o (underflow)
    );

    // Unsupported heads are dropped without needing a credit; supported heads
    // wait for both a credit and room in their own lane, never bypassing.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q | underflow;
        vClr    = 1'b0;
        rClr    = 1'b0;
        vPush   = 1'b0;
        rPush   = 1'b0;
        pop     = 1'b0;
        case (state_q)
            INIT: begin
                vClr    = 1'b1;
                rClr    = 1'b1;
                idx_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (!bus.in_fifo_empty) begin
                    if (headLane == LANE_UNSUP) begin
                        state_d = DROP;
                    end else if (!atMax) begin
                        if (headLane == LANE_VARINT && !bus.varint_fifo_full) begin
                            state_d = V_ISSUE;
                        end else if (headLane == LANE_RAW && !bus.raw_fifo_full) begin
                            state_d = R_ISSUE;
                        end
                    end
                end
            end
            V_ISSUE: begin
                vPush   = 1'b1;
                pop     = 1'b1;
                idx_d   = idx_q + IDX_W'(1);
                state_d = WAIT;
            end
            R_ISSUE: begin
                rPush   = 1'b1;
                pop     = 1'b1;
                idx_d   = idx_q + IDX_W'(1);
                state_d = WAIT;
            end
            DROP: begin
                pop     = 1'b1;
                err_d   = 1'b1;
                state_d = WAIT;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_fifo_pop       = pop;
    assign bus.varint_fifo_clr   = vClr;
    assign bus.varint_fifo_push  = vPush;
    assign bus.varint_fifo_index = idx_q;
    assign bus.raw_fifo_clr      = rClr;
    assign bus.raw_fifo_push     = rPush;
    assign bus.raw_fifo_index    = idx_q;
    assign bus.busy              = nonzero;
    assign bus.err               = err_q;

endmodule

// File: tb/tb_field_dispatch.sv
// Self-checking bench for field_dispatch: models the input FIFO, lane fullness
// and merge-stage retires, and predicts lane/index order from wire types.
module tb_field_dispatch;

    logic clk = 1'b0;
    logic reset = 1'b1;

    field_dispatch_if bus ();

    field_dispatch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Stimulus owned by the initial block
    logic [2:0] inTypes[$];
    int         flushTo = 0;
    int         creditBase = 0;
    int         logBase = 0;
    int         popBase = 0;
    logic       manualRetire = 1'b0;
    logic       autoRetireEn = 1'b0;
    int         autoRetirePct = 100;
    logic       randFullEn = 1'b0;
    logic       forceVFull = 1'b0;
    logic       forceRFull = 1'b0;

    // Reference model: expected lane (0 varint, 1 raw) and index per issued record
    int         expLane[$];
    int         expIdx[$];
    int         mIdx = 0;
    logic       mErr = 1'b0;

    // Owned by the monitor
    int         logLane[$];
    int         logIdx[$];
    int         logCyc[$];
    int         popCount = 0;
    int         pushTotal = 0;
    int         retireCount = 0;
    int         clrVCount = 0;
    int         clrRCount = 0;
    int         cycle = 0;

    // Owned by the input-FIFO / environment process
    int         rdPtr = 0;
    int         popsApplied = 0;
    logic       inEmpty = 1'b1;
    logic [2:0] inHead = 3'd0;
    logic       autoRetire = 1'b0;
    logic       vFullRand = 1'b0;
    logic       rFullRand = 1'b0;

    assign bus.in_fifo_empty    = inEmpty;
    assign bus.in_fifo_q        = inHead;
    assign bus.varint_fifo_full = forceVFull | vFullRand;
    assign bus.raw_fifo_full    = forceRFull | rFullRand;
    assign bus.retire           = manualRetire | autoRetire;

    always @(negedge clk) begin
        cycle++;
        if (bus.varint_fifo_push) begin
            logLane.push_back(0);
            logIdx.push_back(int'(bus.varint_fifo_index));
            logCyc.push_back(cycle);
            pushTotal++;
        end
        if (bus.raw_fifo_push) begin
            logLane.push_back(1);
            logIdx.push_back(int'(bus.raw_fifo_index));
            logCyc.push_back(cycle);
            pushTotal++;
        end
        if (bus.in_fifo_pop) popCount++;
        if (bus.varint_fifo_clr) clrVCount++;
        if (bus.raw_fifo_clr) clrRCount++;
        if (bus.retire) retireCount++;
    end

    // Show-ahead input FIFO plus random lane-full and retire generation
    always @(posedge clk) begin : envProc
        int n;
        #1;
        n = popCount - popsApplied;
        popsApplied = popCount;
        rdPtr = rdPtr + n;
        if (rdPtr < flushTo) rdPtr = flushTo;
        if (rdPtr > inTypes.size()) rdPtr = inTypes.size();
        inEmpty = (rdPtr >= inTypes.size());
        inHead = inEmpty ? 3'd0 : inTypes[rdPtr];
        autoRetire = autoRetireEn && ((pushTotal - retireCount - creditBase) > 0)
                     && ($urandom_range(99) < autoRetirePct);
        vFullRand = randFullEn && ($urandom_range(3) == 0);
        rFullRand = randFullEn && ($urandom_range(3) == 0);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic syncAfterReset();
        flushTo = inTypes.size();
        logBase = logIdx.size();
        popBase = popCount;
        creditBase = pushTotal - retireCount;
        expLane.delete();
        expIdx.delete();
        mIdx = 0;
        mErr = 1'b0;
    endtask

    task automatic doReset(input int n);
        autoRetireEn = 1'b0;
        randFullEn = 1'b0;
        forceVFull = 1'b0;
        forceRFull = 1'b0;
        manualRetire = 1'b0;
        reset = 1'b1;
        tick(n);
        reset = 1'b0;
        syncAfterReset();
    endtask

    task automatic feed(input logic [2:0] t);
        inTypes.push_back(t);
        if (t == 3'd0) begin
            expLane.push_back(0);
            expIdx.push_back(mIdx);
            mIdx = (mIdx + 1) % 1024;
        end else if (t == 3'd1 || t == 3'd2 || t == 3'd5) begin
            expLane.push_back(1);
            expIdx.push_back(mIdx);
            mIdx = (mIdx + 1) % 1024;
        end else begin
            mErr = 1'b1;
        end
    endtask

    function automatic logic [2:0] randSupported();
        logic [2:0] sup[4] = '{3'd0, 3'd1, 3'd2, 3'd5};
        return sup[$urandom_range(3)];
    endfunction

    task automatic waitPushes(input int target, input int budget, output logic ok);
        int k = 0;
        while ((logIdx.size() - logBase) < target && k < budget) begin
            tick();
            k++;
        end
        ok = ((logIdx.size() - logBase) >= target);
    endtask

    task automatic waitPops(input int target, input int budget, output logic ok);
        int k = 0;
        while ((popCount - popBase) < target && k < budget) begin
            tick();
            k++;
        end
        ok = ((popCount - popBase) >= target);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++;
        if ({bus.varint_fifo_push, bus.raw_fifo_push, bus.in_fifo_pop} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_push_pop got %b expected 000",
                     {bus.varint_fifo_push, bus.raw_fifo_push, bus.in_fifo_pop});
        end
        checks++;
        if (bus.varint_fifo_index !== 10'd0 || bus.raw_fifo_index !== 10'd0) begin
            failures++;
            $display("[TB] FAIL reset_index got %0d/%0d expected 0/0",
                     bus.varint_fifo_index, bus.raw_fifo_index);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy_err got %b%b expected 00", bus.busy, bus.err);
        end
        reset = 1'b0;
        syncAfterReset();
        checks++;
        if (bus.varint_fifo_clr !== 1'b1 || bus.raw_fifo_clr !== 1'b1) begin
            failures++;
            $display("[TB] FAIL init_clr got %b%b expected 11", bus.varint_fifo_clr, bus.raw_fifo_clr);
        end
        tick();
        checks++;
        if (bus.varint_fifo_clr !== 1'b0 || bus.raw_fifo_clr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clr_after_init got %b%b expected 00", bus.varint_fifo_clr, bus.raw_fifo_clr);
        end
    endtask

    task automatic test_varint_stream();
        logic ok;
        doReset(2);
        repeat (5) feed(3'd0);
        waitPushes(5, 40, ok);
        tick(4);
        checks++;
        if (!ok || (logIdx.size() - logBase) != 5) begin
            failures++;
            $display("[TB] FAIL varint_count got %0d pushes expected 5", logIdx.size() - logBase);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (logLane[logBase+i] !== 0 || logIdx[logBase+i] !== i) begin
                    failures++;
                    $display("[TB] FAIL varint_entry%0d got lane %0d idx %0d expected lane 0 idx %0d",
                             i, logLane[logBase+i], logIdx[logBase+i], i);
                end
            end
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (logCyc[logBase+i] - logCyc[logBase+i-1] != 2) begin
                    failures++;
                    $display("[TB] FAIL varint_spacing%0d got %0d cycles expected 2",
                             i, logCyc[logBase+i] - logCyc[logBase+i-1]);
                end
            end
        end
        checks++;
        if (bus.busy !== 1'b1 || (popCount - popBase) != 5) begin
            failures++;
            $display("[TB] FAIL varint_busy_pops got busy %b pops %0d expected busy 1 pops 5",
                     bus.busy, popCount - popBase);
        end
    endtask

    task automatic test_interleave();
        logic ok;
        logic [2:0] seq[5] = '{3'd0, 3'd2, 3'd5, 3'd1, 3'd0};
        int lanes[5] = '{0, 1, 1, 1, 0};
        doReset(2);
        for (int i = 0; i < 5; i++) feed(seq[i]);
        waitPushes(5, 40, ok);
        tick(4);
        checks++;
        if (!ok || (popCount - popBase) != 5) begin
            failures++;
            $display("[TB] FAIL interleave_pops got %0d expected 5", popCount - popBase);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (logBase + i >= logIdx.size()) begin
                failures++;
                $display("[TB] FAIL interleave_entry%0d missing, expected lane %0d idx %0d", i, lanes[i], i);
            end else if (logLane[logBase+i] !== lanes[i] || logIdx[logBase+i] !== i) begin
                failures++;
                $display("[TB] FAIL interleave_entry%0d got lane %0d idx %0d expected lane %0d idx %0d",
                         i, logLane[logBase+i], logIdx[logBase+i], lanes[i], i);
            end
        end
    endtask

    task automatic test_drop();
        logic ok;
        doReset(2);
        feed(3'd3);
        feed(3'd0);
        waitPushes(1, 40, ok);
        tick(2);
        checks++;
        if (!ok || bus.err !== 1'b1 || logLane[logBase] !== 0 || logIdx[logBase] !== 0) begin
            failures++;
            $display("[TB] FAIL drop_then_varint got err %b pushes %0d expected err 1, lane 0 idx 0",
                     bus.err, logIdx.size() - logBase);
        end
        checks++;
        if ((popCount - popBase) != 2) begin
            failures++;
            $display("[TB] FAIL drop_pops got %0d expected 2", popCount - popBase);
        end
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(1) == 0) feed(3'd4 + 3'($urandom_range(3)) == 3'd5 ? 3'd6 : 3'd4 + 3'($urandom_range(3)));
            else feed(randSupported());
        end
        waitPops(14, 200, ok);
        tick(4);
        checks++;
        if (!ok || (logIdx.size() - logBase) != expIdx.size()) begin
            failures++;
            $display("[TB] FAIL drop_mix_count got %0d pushes expected %0d", logIdx.size() - logBase, expIdx.size());
        end
        for (int i = 0; i < expIdx.size() && logBase + i < logIdx.size(); i++) begin
            checks++;
            if (logLane[logBase+i] !== expLane[i] || logIdx[logBase+i] !== expIdx[i]) begin
                failures++;
                $display("[TB] FAIL drop_mix_entry%0d got lane %0d idx %0d expected lane %0d idx %0d",
                         i, logLane[logBase+i], logIdx[logBase+i], expLane[i], expIdx[i]);
            end
        end
        checks++;
        if (bus.err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL err_sticky got %b expected 1", bus.err);
        end
    endtask

    task automatic test_credit();
        logic ok;
        int k;
        doReset(2);
        for (int i = 0; i < 520; i++) feed(randSupported());
        waitPushes(512, 1500, ok);
        tick(20);
        checks++;
        if (!ok || (logIdx.size() - logBase) != 512 || (popCount - popBase) != 512) begin
            failures++;
            $display("[TB] FAIL credit_stall got pushes %0d pops %0d expected 512/512",
                     logIdx.size() - logBase, popCount - popBase);
        end
        manualRetire = 1'b1;
        tick();
        manualRetire = 1'b0;
        tick(20);
        checks++;
        if ((logIdx.size() - logBase) != 513) begin
            failures++;
            $display("[TB] FAIL credit_one_retire got %0d pushes expected 513", logIdx.size() - logBase);
        end
        manualRetire = 1'b1;
        tick();
        manualRetire = 1'b0;
        k = 0;
        while (!(bus.varint_fifo_push || bus.raw_fifo_push) && k < 20) begin
            tick();
            k++;
        end
        manualRetire = 1'b1;
        tick();
        manualRetire = 1'b0;
        tick(30);
        checks++;
        if ((logIdx.size() - logBase) != 515 || bus.busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL credit_issue_and_retire got %0d pushes busy %b expected 515 busy 1",
                     logIdx.size() - logBase, bus.busy);
        end
        autoRetireEn = 1'b1;
        autoRetirePct = 100;
        waitPushes(520, 100, ok);
        k = 0;
        while (bus.busy !== 1'b0 && k < 1200) begin
            tick();
            k++;
        end
        checks++;
        if (!ok || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL credit_drain got pushes %0d busy %b expected 520 busy 0",
                     logIdx.size() - logBase, bus.busy);
        end
        for (int i = 0; i < expIdx.size() && logBase + i < logIdx.size(); i++) begin
            checks++;
            if (logLane[logBase+i] !== expLane[i] || logIdx[logBase+i] !== expIdx[i]) begin
                failures++;
                $display("[TB] FAIL credit_entry%0d got lane %0d idx %0d expected lane %0d idx %0d",
                         i, logLane[logBase+i], logIdx[logBase+i], expLane[i], expIdx[i]);
            end
        end
        autoRetireEn = 1'b0;
    endtask

    task automatic test_wrap();
        logic ok;
        int wrapIdx[3] = '{1022, 1023, 0};
        doReset(2);
        autoRetireEn = 1'b1;
        autoRetirePct = 100;
        for (int i = 0; i < 1025; i++) feed(randSupported());
        waitPushes(1025, 3000, ok);
        tick(4);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL wrap_count got %0d pushes expected 1025", logIdx.size() - logBase);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (logIdx[logBase+1022+i] !== wrapIdx[i] || logLane[logBase+1022+i] !== expLane[1022+i]) begin
                    failures++;
                    $display("[TB] FAIL wrap_entry%0d got lane %0d idx %0d expected lane %0d idx %0d",
                             1022 + i, logLane[logBase+1022+i], logIdx[logBase+1022+i],
                             expLane[1022+i], wrapIdx[i]);
                end
            end
        end
        autoRetireEn = 1'b0;
    endtask

    task automatic test_strict_order_and_reset();
        logic ok;
        int clrV0;
        int clrR0;
        doReset(2);
        forceRFull = 1'b1;
        feed(3'd2);
        feed(3'd0);
        tick(12);
        checks++;
        if ((logIdx.size() - logBase) != 0 || (popCount - popBase) != 0) begin
            failures++;
            $display("[TB] FAIL hol_block got pushes %0d pops %0d expected 0/0",
                     logIdx.size() - logBase, popCount - popBase);
        end
        forceRFull = 1'b0;
        waitPushes(2, 20, ok);
        checks++;
        if (!ok || logLane[logBase] !== 1 || logIdx[logBase] !== 0
            || logLane[logBase+1] !== 0 || logIdx[logBase+1] !== 1) begin
            failures++;
            $display("[TB] FAIL hol_release got %0d pushes expected raw idx 0 then varint idx 1",
                     logIdx.size() - logBase);
        end
        feed(3'd7);
        for (int i = 0; i < 10; i++) feed(3'd0);
        waitPops(5, 40, ok);
        clrV0 = clrVCount;
        clrR0 = clrRCount;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({bus.varint_fifo_push, bus.raw_fifo_push, bus.in_fifo_pop} !== 3'b000
            || bus.varint_fifo_index !== 10'd0 || bus.err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_state got push/pop %b idx %0d err %b expected 000 0 0",
                     {bus.varint_fifo_push, bus.raw_fifo_push, bus.in_fifo_pop}, bus.varint_fifo_index, bus.err);
        end
        syncAfterReset();
        tick(3);
        checks++;
        if ((clrVCount - clrV0) != 1 || (clrRCount - clrR0) != 1) begin
            failures++;
            $display("[TB] FAIL midreset_clr got %0d/%0d cycles expected 1/1",
                     clrVCount - clrV0, clrRCount - clrR0);
        end
        feed(3'd5);
        waitPushes(1, 20, ok);
        checks++;
        if (!ok || logLane[logBase] !== 1 || logIdx[logBase] !== 0) begin
            failures++;
            $display("[TB] FAIL midreset_restart got %0d pushes expected raw idx 0", logIdx.size() - logBase);
        end
    endtask

    task automatic test_random();
        logic ok;
        doReset(2);
        randFullEn = 1'b1;
        autoRetireEn = 1'b1;
        autoRetirePct = 50;
        for (int i = 0; i < 300; i++) feed(3'($urandom_range(7)));
        waitPops(300, 6000, ok);
        tick(4);
        checks++;
        if (!ok || (logIdx.size() - logBase) != expIdx.size()) begin
            failures++;
            $display("[TB] FAIL random_count got pops %0d pushes %0d expected pops 300 pushes %0d",
                     popCount - popBase, logIdx.size() - logBase, expIdx.size());
        end
        for (int i = 0; i < expIdx.size() && logBase + i < logIdx.size(); i++) begin
            checks++;
            if (logLane[logBase+i] !== expLane[i] || logIdx[logBase+i] !== expIdx[i]) begin
                failures++;
                $display("[TB] FAIL random_entry%0d got lane %0d idx %0d expected lane %0d idx %0d",
                         i, logLane[logBase+i], logIdx[logBase+i], expLane[i], expIdx[i]);
            end
        end
        checks++;
        if (bus.err !== mErr) begin
            failures++;
            $display("[TB] FAIL random_err got %b expected %b", bus.err, mErr);
        end
        randFullEn = 1'b0;
        autoRetireEn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_varint_stream();
        test_interleave();
        test_drop();
        test_credit();
        test_wrap();
        test_strict_order_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
